// File: rtl/bcd_entry_pkg.sv
// Shared definitions for the BCD digit-entry block: FSM encoding and the
// largest legal decimal digit.
package bcd_entry_pkg;

  typedef enum logic [1:0] {
    ENTRY = 2'b00,
    REQ   = 2'b01,
    WAIT  = 2'b10
  } state_e;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/bcd_digit_entry.sv
// Two-digit BCD keypad entry with a start/done handshake to a downstream
// converter. Define BCD_ENTRY_TIMEOUT_EN to abandon WAIT after TIMEOUT cycles.
module bcd_digit_entry
  import bcd_entry_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       enter,
  input  logic       clear,
  input  logic       conv_ready,
  input  logic       conv_done,
  output logic       start,
  output logic [3:0] bcd1,
  output logic [3:0] bcd0,
  output logic [1:0] count,
  output logic       busy,
  output logic       err_tick
);

  state_e     state_q, state_d;
  logic [3:0] bcd1_q, bcd1_d;
  logic [3:0] bcd0_q, bcd0_d;
  logic [1:0] count_q, count_d;
  logic       start_d;
  logic       err_d;
  logic       tmo_hit;

`ifdef BCD_ENTRY_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] tmo_q;

  // Held at zero outside WAIT, so it starts from zero on every entry to WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q <= '0;
    end else if (state_q != WAIT) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  assign tmo_hit = (state_q == WAIT) && (tmo_q == TW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign tmo_hit        = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ENTRY;
      bcd1_q  <= '0;
      bcd0_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      bcd1_q  <= bcd1_d;
      bcd0_q  <= bcd0_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bcd1_d  = bcd1_q;
    bcd0_d  = bcd0_q;
    count_d = count_q;
    start_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ENTRY: begin
        // clear outranks enter, which outranks a digit strobe.
        if (clear) begin
          bcd1_d  = '0;
          bcd0_d  = '0;
          count_d = '0;
        end else if (enter) begin
          if (count_q != 2'd0) begin
            state_d = REQ;
          end else begin
            err_d = 1'b1;
          end
        end else if (digit_valid) begin
          if (digit > BCD_MAX_DIGIT) begin
            err_d = 1'b1;
          end else begin
            bcd1_d  = bcd0_q;
            bcd0_d  = digit;
            count_d = (count_q == 2'd2) ? 2'd2 : count_q + 2'd1;
          end
        end
      end
      REQ: begin
        if (conv_ready) begin
          start_d = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // conv_done beats a coincident timeout and suppresses its error.
        if (conv_done || tmo_hit) begin
          state_d = ENTRY;
          bcd1_d  = '0;
          bcd0_d  = '0;
          count_d = '0;
          err_d   = !conv_done;
        end
      end
      default: begin
        state_d = ENTRY;
      end
    endcase
  end

  assign start    = start_d && !reset;
  assign err_tick = err_d && !reset;
  assign busy     = (state_q != ENTRY);
  assign bcd1     = bcd1_q;
  assign bcd0     = bcd0_q;
  assign count    = count_q;

endmodule
